// File: rtl/res_ram_arbiter_if.sv
// Client-side port of the result-RAM arbiter: command/request in, grant and
// read data back. The arbiter takes the slave modport, a client the master.
interface res_ram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/res_ram_arbiter.sv
// Two-client arbiter for the single-port result RAM: one registered command per
// cycle, read data steered back to the issuing client two edges after grant.
module res_ram_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 14,
    parameter int DW       = 8
) (
    input  logic             clk,
    input  logic             reset,
    res_ram_arbiter_if.slave c0,
    res_ram_arbiter_if.slave c1,
    output logic             res_rd,
    output logic             res_wr,
    output logic [AW-1:0]    res_addr,
    output logic [DW-1:0]    res_do,
    input  logic [DW-1:0]    res_di
);
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [1:0]         req, gnt;
    cmd_t [1:0]         cmd;
    cmd_t               win_cmd;
    logic               win, any_gnt;

    logic [7:0]         wait_cnt_d, wait_cnt_q;
    logic               rr_ptr_d, rr_ptr_q;
    logic               res_rd_d, res_rd_q, res_wr_d, res_wr_q;
    logic [AW-1:0]      res_addr_d, res_addr_q;
    logic [DW-1:0]      res_do_d, res_do_q;
    logic               tag_vld_d, tag_vld_q, tag_id_d, tag_id_q;
    logic [1:0]         rvalid_d, rvalid_q;
    logic [1:0][DW-1:0] rdata_d, rdata_q;

    assign req    = {c1.req, c0.req};
    assign cmd[0] = {c0.we, c0.addr, c0.wdata};
    assign cmd[1] = {c1.we, c1.addr, c1.wdata};

    always_comb begin
        gnt = '0;
        if (ARB_MODE == 0) begin
            // c1 only beats a requesting c0 once it has aged out
            if (req[1] && (!req[0] || wait_cnt_q == WAIT_LIM)) gnt[1] = 1'b1;
            else if (req[0])                                   gnt[0] = 1'b1;
        end else begin
            if (req == 2'b11) gnt[rr_ptr_q] = 1'b1;
            else              gnt = req;
        end
    end

    assign win     = gnt[1];
    assign any_gnt = |gnt;
    assign win_cmd = cmd[win];

    always_comb begin
        wait_cnt_d = '0;
        if (req[1] && !gnt[1])
            wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 8'd1;
        rr_ptr_d = any_gnt ? ~win : rr_ptr_q;
    end

    // Command stage: registered toward the RAM, tag remembers who owns a read.
    always_comb begin
        res_rd_d   = any_gnt & ~win_cmd.we;
        res_wr_d   = any_gnt &  win_cmd.we;
        res_addr_d = any_gnt ? win_cmd.addr  : res_addr_q;
        res_do_d   = any_gnt ? win_cmd.wdata : res_do_q;
        tag_vld_d  = any_gnt & ~win_cmd.we;
        tag_id_d   = win;
    end

    // Response stage: RAM data sampled on the negedge is stable by this posedge.
    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_vld_q) begin
            rvalid_d[tag_id_q] = 1'b1;
            rdata_d[tag_id_q]  = res_di;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
            res_rd_q   <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_do_q   <= '0;
            tag_vld_q  <= 1'b0;
            tag_id_q   <= 1'b0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            res_rd_q   <= res_rd_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_do_q   <= res_do_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign c0.gnt    = gnt[0];
    assign c1.gnt    = gnt[1];
    assign c0.rvalid = rvalid_q[0];
    assign c1.rvalid = rvalid_q[1];
    assign c0.rdata  = rdata_q[0];
    assign c1.rdata  = rdata_q[1];
    assign res_rd    = res_rd_q;
    assign res_wr    = res_wr_q;
    assign res_addr  = res_addr_q;
    assign res_do    = res_do_q;
endmodule

// File: tb/tb_res_ram_arbiter.sv
// Bench for res_ram_arbiter: an ARB_MODE 0 and an ARB_MODE 1 instance, each on
// its own RAM model, checked every cycle against a transaction-level reference.
module tb_res_ram_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0][1:0]          req_b, we_b;
    logic [1:0][1:0][AW-1:0]  addr_b;
    logic [1:0][1:0][DW-1:0]  wd_b;
    wire  [1:0][1:0]          gnt_b, rv_b;
    wire  [1:0][1:0][DW-1:0]  rd_b;
    wire  [1:0]               rrd_b, rwr_b;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        res_ram_arbiter_if #(.AW(AW), .DW(DW)) c0 ();
        res_ram_arbiter_if #(.AW(AW), .DW(DW)) c1 ();
        logic          ram_rd, ram_wr;
        logic [AW-1:0] ram_addr;
        logic [DW-1:0] ram_do, ram_di;
        logic [DW-1:0] mem [1<<AW];

        assign c0.req   = req_b[m][0];
        assign c0.we    = we_b[m][0];
        assign c0.addr  = addr_b[m][0];
        assign c0.wdata = wd_b[m][0];
        assign c1.req   = req_b[m][1];
        assign c1.we    = we_b[m][1];
        assign c1.addr  = addr_b[m][1];
        assign c1.wdata = wd_b[m][1];
        assign gnt_b[m] = {c1.gnt, c0.gnt};
        assign rv_b[m]  = {c1.rvalid, c0.rvalid};
        assign rd_b[m]  = {c1.rdata, c0.rdata};
        assign rrd_b[m] = ram_rd;
        assign rwr_b[m] = ram_wr;

        res_ram_arbiter #(.ARB_MODE(m), .MAX_WAIT(MW), .AW(AW), .DW(DW)) u_dut (
            .clk(clk), .reset(reset), .c0(c0), .c1(c1),
            .res_rd(ram_rd), .res_wr(ram_wr), .res_addr(ram_addr),
            .res_do(ram_do), .res_di(ram_di));

        always @(posedge clk) if (ram_wr) mem[ram_addr] <= ram_do;
        always @(negedge clk) if (ram_rd) ram_di <= mem[ram_addr];
    end

    typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } cmd_t;
    typedef struct { int c; logic [DW-1:0] d; bit known; int due; } rexp_t;

    cmd_t          cq [2][2][$];
    rexp_t         exp_q [2][$];
    logic [DW-1:0] ref_mem [2][1<<AW];
    bit            ref_known [2][1<<AW];
    int            wcnt [2], pref [2], win_m [2];
    bit   [1:0]    pcmd_rd, pcmd_wr;
    logic [DW-1:0] ldat [2][2];
    bit            lknown [2][2];
    logic [1:0][1:0]         obs_g, obs_rv;
    logic [1:0][1:0][DW-1:0] obs_rd;
    int cyc, n_vec, n_bad;
    bit rand_abort;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            wcnt[m] = 0; pref[m] = 0; win_m[m] = -1;
            exp_q[m].delete();
            for (int c = 0; c < 2; c++) begin
                cq[m][c].delete();
                ldat[m][c] = '0; lknown[m][c] = 1'b1;
            end
        end
        pcmd_rd = '0; pcmd_wr = '0;
        req_b = '0;
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++) begin
                if (req_b[m][c] && win_m[m] == c) req_b[m][c] = 1'b0;
                else if (req_b[m][c] && rand_abort && $urandom_range(15) == 0) req_b[m][c] = 1'b0;
                if (!req_b[m][c] && cq[m][c].size() > 0) begin
                    cmd_t k = cq[m][c].pop_front();
                    req_b[m][c] = 1'b1; we_b[m][c] = k.we;
                    addr_b[m][c] = k.a;  wd_b[m][c] = k.d;
                end
            end
    endtask

    task automatic check(input int m);
        bit r0 = req_b[m][0];
        bit r1 = req_b[m][1];
        int w = -1;
        bit [1:0] erv = '0;
        rexp_t e;
        obs_g[m] = gnt_b[m]; obs_rv[m] = rv_b[m]; obs_rd[m] = rd_b[m];
        if (m == 0) begin
            if (r1 && (!r0 || wcnt[m] == MW)) w = 1;
            else if (r0)                      w = 0;
        end else begin
            if (r0 && r1)  w = pref[m];
            else if (r0)   w = 0;
            else if (r1)   w = 1;
        end
        chk($sformatf("gnt0_m%0d", m), 32'(gnt_b[m][0]), 32'(w == 0));
        chk($sformatf("gnt1_m%0d", m), 32'(gnt_b[m][1]), 32'(w == 1));
        chk($sformatf("res_rd_m%0d", m), 32'(rrd_b[m]), 32'(pcmd_rd[m]));
        chk($sformatf("res_wr_m%0d", m), 32'(rwr_b[m]), 32'(pcmd_wr[m]));
        if (exp_q[m].size() > 0 && exp_q[m][0].due == cyc) begin
            e = exp_q[m].pop_front();
            erv[e.c] = 1'b1;
            ldat[m][e.c] = e.d; lknown[m][e.c] = e.known;
        end
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rvalid%0d_m%0d", c, m), 32'(rv_b[m][c]), 32'(erv[c]));
            if (lknown[m][c]) chk($sformatf("rdata%0d_m%0d", c, m), 32'(rd_b[m][c]), 32'(ldat[m][c]));
        end
        wcnt[m] = (r1 && w != 1) ? ((wcnt[m] < MW) ? wcnt[m] + 1 : MW) : 0;
        pcmd_rd[m] = 1'b0; pcmd_wr[m] = 1'b0;
        if (w >= 0) begin
            pref[m] = 1 - w;
            if (we_b[m][w]) begin
                pcmd_wr[m] = 1'b1;
                ref_mem[m][addr_b[m][w]] = wd_b[m][w];
                ref_known[m][addr_b[m][w]] = 1'b1;
            end else begin
                pcmd_rd[m] = 1'b1;
                exp_q[m].push_back('{w, ref_mem[m][addr_b[m][w]], ref_known[m][addr_b[m][w]], cyc + 2});
            end
        end
        win_m[m] = w;
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        check(0);
        check(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int m, input int c, input bit we, input int a, input int d);
        cq[m][c].push_back('{we, AW'(a), DW'(d)});
    endtask

    task automatic drain();
        int n = 0;
        while ((cq[0][0].size() + cq[0][1].size() + cq[1][0].size() + cq[1][1].size() > 0 ||
                req_b != '0 || exp_q[0].size() + exp_q[1].size() > 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(n), 32'd0);
        tick();
    endtask

    initial begin
        int n;
        cyc = 0; n_vec = 0; n_bad = 0; rand_abort = 1'b0;
        we_b = '0; addr_b = '0; wd_b = '0;
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < (1<<AW); a++) ref_known[m][a] = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();

        // round-robin from reset pointer
        for (int i = 0; i < 3; i++) begin
            push(1, 0, 1'b0, 16'h0040 + i, 0);
            push(1, 1, 1'b0, 16'h0050 + i, 0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr_order%0d", i), 32'(obs_g[1]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        drain();

        // write then read on the same address
        push(0, 0, 1'b1, 16'h1234, 8'h5A);
        push(0, 0, 1'b0, 16'h1234, 0);
        tick(); tick(); tick();
        chk("wr_rd_early", 32'(obs_rv[0][0]), 32'd0);
        tick();
        chk("wr_rd_rvalid", 32'(obs_rv[0][0]), 32'd1);
        chk("wr_rd_data", 32'(obs_rd[0][0]), 32'h5A);
        chk("wr_rd_c1_quiet", 32'(obs_rv[0][1]), 32'd0);
        drain();

        // aging: c1 wins on its 9th requesting cycle
        push(0, 1, 1'b1, 16'h0010, 8'hC3);
        drain();
        for (int i = 0; i < 20; i++) push(0, 0, 1'b0, 16'h0020 + i, 0);
        push(0, 1, 1'b0, 16'h0010, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_g[0][1] && n < 40);
        chk("age_wait", 32'(n), 32'd9);
        chk("age_c0_deny", 32'(obs_g[0][0]), 32'd0);
        tick();
        chk("age_c0_resume", 32'(obs_g[0][0]), 32'd1);
        drain();

        // interleaved reads, no cross-delivery
        push(0, 0, 1'b1, 16'h0001, 8'h11);
        push(0, 1, 1'b1, 16'h0002, 8'h22);
        drain();
        push(0, 0, 1'b0, 16'h0001, 0);
        push(0, 1, 1'b0, 16'h0002, 0);
        tick(); tick(); tick();
        chk("il_c0_rv", 32'(obs_rv[0]), 32'd1);
        chk("il_c0_data", 32'(obs_rd[0][0]), 32'h11);
        tick();
        chk("il_c1_rv", 32'(obs_rv[0]), 32'd2);
        chk("il_c1_data", 32'(obs_rd[0][1]), 32'h22);
        drain();

        // reset between E1 and E2 of a c1 read
        push(0, 1, 1'b0, 16'h0010, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_g[0][1] && n < 20);
        chk("rst_rd_before", 32'(rrd_b[0]), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_rd_async", 32'(rrd_b[0]), 32'd0);
        chk("rst_rdata_async", 32'(rd_b[0][1]), 32'd0);
        model_reset();
        tick(); tick();
        reset = 1'b1;
        repeat (3) tick();
        push(0, 1, 1'b0, 16'h0010, 0);
        drain();
        chk("rst_after_data", 32'(rd_b[0][1]), 32'hC3);

        // randomized traffic on both instances
        rand_abort = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            for (int m = 0; m < 2; m++)
                for (int c = 0; c < 2; c++)
                    if (cq[m][c].size() == 0 && $urandom_range(2) == 0)
                        push(m, c, 1'($urandom_range(1)),
                             ($urandom_range(3) == 0) ? int'($urandom_range((1<<AW) - 1))
                                                      : 16'h0100 + int'($urandom_range(7)),
                             int'($urandom_range(255)));
            tick();
        end
        rand_abort = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/res_ram_arbiter.md
Name: res_ram_arbiter

Overview:
- Two-client arbiter that shares the single-port 16384x8 result RAM.
- Client 0 is the distance-transform engine (forward and backward pass). Client 1 is the host/readback or debug port.
- Registers one RAM command per cycle, matches the RAM's negedge-read / posedge-write timing, and returns read data to the correct client.
- Prevents client-1 starvation by aging (ARB_MODE 0) or by round-robin (ARB_MODE 1).

Parameters:
- ARB_MODE, 0: 0 = client 0 has fixed priority, with aging for client 1; 1 = strict round-robin.
- MAX_WAIT, 8: in ARB_MODE 0, the number of consecutive denied cycles after which client 1 overrides client 0. Legal range is 1..255.
- AW, 14: RAM address width.
- DW, 8: RAM data width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- c0_req  in  1  client 0 request; held until granted.
- c0_we  in  1  client 0 access type: 1 = write, 0 = read.
- c0_addr  in  AW  client 0 address.
- c0_wdata  in  DW  client 0 write data.
- c0_gnt  out  1  client 0 command accepted at the next posedge (combinational).
- c0_rvalid  out  1  client 0 read data valid (one-cycle pulse).
- c0_rdata  out  DW  client 0 read data.
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as client 0, for client 1.
- res_rd  out  1  RAM read strobe; the RAM samples it on negedge.
- res_wr  out  1  RAM write strobe; the RAM writes on posedge.
- res_addr  out  AW  RAM address.
- res_do  out  DW  RAM write data.
- res_di  in  DW  RAM read data; valid from the negedge after res_rd is asserted.

Behaviour:
- Reset (reset=0, asynchronous): all outputs, rr_ptr, wait_cnt and the read-tag pipeline are 0.
- Grant is combinational from the req inputs and arbiter state. Clients must not derive req combinationally from gnt.
- At most one gnt is high per cycle. gnt=0 whenever the matching req=0.
- Winner selection, ARB_MODE 0:
  - c1 wins if c1_req and (not c0_req, or wait_cnt == MAX_WAIT). Otherwise c0 wins when c0_req.
  - wait_cnt increments when c1_req=1 and c1_gnt=0, saturating at MAX_WAIT.
  - wait_cnt clears when c1 is granted or c1_req=0.
- Winner selection, ARB_MODE 1:
  - If both clients request, the client selected by rr_ptr wins. After each grant, rr_ptr points to the other client.
  - A single requester always wins, and rr_ptr still updates.
- Command stage, posedge E1 after a grant:
  - res_addr and res_do load the winner's addr and wdata.
  - res_wr = winner we; res_rd = not winner we.
  - Read tag loads the winner index, valid.
- With no grant, res_rd=res_wr=0 at E1. res_addr and res_do hold their previous values.
- Response stage, posedge E2: if the tag is a valid read, the owner's rdata captures res_di and the owner's rvalid is 1 for the cycle following E2. rdata holds until the next read for that client.
- Read latency: gnt cycle, then E1 (command), then E2 (data). rvalid is high two posedges after the grant edge.
- Throughput: one access per cycle. Back-to-back reads from either client are fully pipelined, so c0 and c1 rvalid pulses can occur on consecutive cycles.
- A write completes at E2 (the RAM posedge write). Writes return no rvalid.
- RAW ordering: a read granted in the cycle after a write to the same address returns the new data. This holds because the RAM write at E2 precedes the read sample at the following negedge.
- Simultaneous requests are resolved by the mode rules above. The losing client keeps its req and fields stable.
- A client dropping req before gnt is legal (abort). Its wait_cnt clears.
- Reset asserted mid-operation: the in-flight read is discarded and no rvalid is issued after reset release. RAM contents are not touched by the arbiter.
- Address is passed unmodified. All AW bits are valid, with no wrap logic.

Test Plan:
- Reset and idle: reset=0 then 1, no req for 5 cycles -> all outputs 0 and res_rd=res_wr=0 throughout.
- Single client write then read:
  - c0 writes addr 0x1234 data 0x5A.
  - Next cycle, c0 reads 0x1234.
  - Required: c0_rvalid high exactly 2 edges after the read grant, c0_rdata=0x5A, c1_rvalid stays 0.
- Fixed-priority aging, ARB_MODE 0, MAX_WAIT=8:
  - c0_req held high continuously with reads; c1 reads addr 0x0010.
  - Required: c1_gnt first asserts in the 9th cycle of c1_req. c0 is denied that cycle, then resumes.
- Round-robin, ARB_MODE 1: both clients request for 6 cycles -> grants alternate c0, c1, c0, c1, c0, c1 (rr_ptr=0 at reset).
- Interleaved reads:
  - c0 reads 0x0001 (preloaded 0x11) and c1 reads 0x0002 (preloaded 0x22) in consecutive grants.
  - Required: c0_rvalid with 0x11, then c1_rvalid with 0x22 on the next cycle. No cross-delivery.
- Reset mid-read:
  - Assert reset between E1 and E2 of a c1 read.
  - Required: no c1_rvalid after release, all outputs 0, and the next transaction behaves as from reset.
